imem_loader: RTL

- Boot-time program loader for the instruction memory.
- Accepts a byte stream (header and program words) from a serial front end and emits one-cycle word writes to the imem write port.
- Holds the CPU (`cpu_hold`) for the whole load; reports completion or error.
- Sits between the UART/debug RX path and imem, beside the core's reset logic.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_byte_packer.sv | 46 ++++
 rtl/imem_loader.sv | 119 +++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        DONE,
        ERR
    } loader_state_e;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int BYTE_CNT_W = $clog2(WORD_BYTES);

    // Byte address of imem word `idx`; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects little-endian stream bytes into a 32-bit word, flagging the cycle
// the final byte arrives so the caller can register the full word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [7:0]            lanes [WORD_BYTES-1];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_cnt <= '0;
        end else if (byte_valid) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

    // NOTE: the lane storage has no reset; byte_cnt restarts at 0, and every
    // lane is rewritten before a word can be emitted, so stale bytes never escape.
    always_ff @(posedge clk) begin
        if (byte_valid && byte_cnt != BYTE_CNT_W'(WORD_BYTES - 1)) begin
            lanes[byte_cnt] <= byte_data;
        end
    end

    assign word_valid = byte_valid && (byte_cnt == BYTE_CNT_W'(WORD_BYTES - 1));

    always_comb begin
        word_data = '0;
        for (int i = 0; i < WORD_BYTES - 1; i++) begin
            word_data[8*i +: 8] = lanes[i];
        end
        word_data[8*(WORD_BYTES-1) +: 8] = byte_data;
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a {count, words...} byte stream and issues one imem word
// write per four accepted bytes while holding the CPU.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_PC     = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS + 1);

    loader_state_e state;
    loader_state_e state_next;

    logic [7:0]       n_lo;
    logic [15:0]      n_words;
    logic [15:0]      n_full;
    logic [IDX_W-1:0] word_idx;
    logic [IDX_W-1:0] idx_next;
    logic             accept;
    logic             hdr_accept;
    logic             n_too_big;
    logic             last_word;
    logic             word_valid;
    logic [31:0]      word_data;

    assign accept     = rx_valid && rx_ready;
    assign hdr_accept = accept && (state == HDR1);
    assign n_full     = {rx_data, n_lo};
    assign n_too_big  = {16'h0000, n_full} > 32'(DEPTH_WORDS);
    assign idx_next   = word_idx + 1'b1;
    assign last_word  = 32'(idx_next) == {16'h0000, n_words};

    // Cleared on the header's last byte so every load starts on lane 0.
    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (hdr_accept),
        .byte_valid (accept && (state == DATA)),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_next
        // unassigned and infers a latch.
        state_next = state;
        case (state)
            IDLE: if (load_req) state_next = HDR0;
            HDR0: if (accept)   state_next = HDR1;
            HDR1: begin
                if (accept) begin
                    if (n_too_big)           state_next = ERR;
                    else if (n_full == '0)   state_next = DONE;
                    else                     state_next = DATA;
                end
            end
            DATA: if (word_valid && last_word) state_next = DONE;
            DONE: state_next = IDLE;
            ERR:  if (load_req) state_next = HDR0;
            default: state_next = IDLE;
        endcase
    end

    assign rx_ready = (state == HDR0) || (state == HDR1) || (state == DATA);
    assign cpu_hold = (state != IDLE);
    assign load_err = (state == ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            n_lo      <= '0;
            n_words   <= '0;
            word_idx  <= '0;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            load_done <= 1'b0;
        end else begin
            we        <= 1'b0;
            load_done <= (state_next == DONE);
            if (accept && state == HDR0) begin
                n_lo <= rx_data;
            end
            if (hdr_accept) begin
                n_words  <= n_full;
                word_idx <= '0;
            end
            if (word_valid) begin
                we       <= 1'b1;
                wdata    <= word_data;
                waddr    <= word_addr(BASE_PC, 32'(word_idx));
                word_idx <= idx_next;
            end
        end
    end

endmodule
